// File: rtl/panda_pkg.sv
// Shared types for the panda divide unit: operation encoding, sequencer states
// and small decode helpers used by the control logic.
package panda_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABS_A  = 3'd1,
        ABS_B  = 3'd2,
        DIVIDE = 3'd3,
        FIXUP  = 3'd4,
        DONE   = 3'd5
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/panda_adder.sv
// Shared add/subtract datapath: sum_o = a_i + b_i, or a_i - b_i when subtract_i
// is set (two's complement, carry-in supplies the +1).
module panda_adder #(
    parameter int Width = 33
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             subtract_i,
    output logic [Width-1:0] sum_o
);

    logic [Width-1:0] b_eff;

    assign b_eff = subtract_i ? ~b_i : b_i;
    assign sum_o = a_i + b_eff + {{(Width-1){1'b0}}, subtract_i};

endmodule

// File: rtl/panda_divider.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) sequencing one shared adder.
// Define PANDA_DIV_FLUSH_EN to add the flush_i abort input.
module panda_divider
    import panda_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef PANDA_DIV_FLUSH_EN
    input  logic             flush_i,
`endif
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  logic [1:0]       op_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o
);

    localparam int CntW = $clog2(Width);

    div_state_e       state_q;
    div_op_e          op_q;
    div_op_e          op_in;
    logic             sign_a_q, sign_b_q;
    logic [Width-1:0] q_q, r_q, b_q, result_q;
    logic [CntW-1:0]  cnt_q;
    logic             valid_q;
    logic             flush;

    logic [Width:0]   adder_a, adder_b, adder_sum;
    logic             adder_sub;
    logic [Width-1:0] fix_val;
    logic             fix_neg;
    logic             in_signed, in_rem, b_zero, overflow;

`ifdef PANDA_DIV_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign op_in     = div_op_e'(op_i);
    assign in_signed = op_is_signed(op_in);
    assign in_rem    = op_is_rem(op_in);
    assign b_zero    = (operand_b_i == '0);
    assign overflow  = in_signed && (operand_a_i == {1'b1, {(Width-1){1'b0}}})
                       && (operand_b_i == '1);

    assign fix_val = op_is_rem(op_q) ? r_q : q_q;
    assign fix_neg = op_is_signed(op_q) &&
                     (op_is_rem(op_q) ? sign_a_q : (sign_a_q ^ sign_b_q));

    // Every negation is 0 - x; the divide step is the trial subtraction.
    always_comb begin
        adder_a   = '0;
        adder_b   = '0;
        adder_sub = 1'b0;
        case (state_q)
            ABS_A: begin
                adder_b   = {1'b0, q_q};
                adder_sub = 1'b1;
            end
            ABS_B: begin
                adder_b   = {1'b0, b_q};
                adder_sub = 1'b1;
            end
            DIVIDE: begin
                adder_a   = {r_q, q_q[Width-1]};
                adder_b   = {1'b0, b_q};
                adder_sub = 1'b1;
            end
            FIXUP: begin
                adder_b   = {1'b0, fix_val};
                adder_sub = 1'b1;
            end
            default: ;
        endcase
    end

    panda_adder #(.Width(Width + 1)) u_adder (
        .a_i        (adder_a),
        .b_i        (adder_b),
        .subtract_i (adder_sub),
        .sum_o      (adder_sum)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            q_q      <= '0;
            r_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
        end else if (flush && (state_q != IDLE)) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && !flush) begin
                        op_q     <= op_in;
                        sign_a_q <= in_signed && operand_a_i[Width-1];
                        sign_b_q <= in_signed && operand_b_i[Width-1];
                        q_q      <= operand_a_i;
                        b_q      <= operand_b_i;
                        r_q      <= '0;
                        if (b_zero) begin
                            result_q <= in_rem ? operand_a_i : '1;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else if (overflow) begin
                            result_q <= in_rem ? '0 : operand_a_i;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q <= ABS_A;
                        end
                    end
                end
                ABS_A: begin
                    if (sign_a_q) q_q <= adder_sum[Width-1:0];
                    state_q <= ABS_B;
                end
                ABS_B: begin
                    if (sign_b_q) b_q <= adder_sum[Width-1:0];
                    cnt_q   <= CntW'(Width - 1);
                    state_q <= DIVIDE;
                end
                DIVIDE: begin
                    // A clear borrow bit means the trial subtraction fit.
                    q_q <= {q_q[Width-2:0], ~adder_sum[Width]};
                    r_q <= adder_sum[Width] ? {r_q[Width-2:0], q_q[Width-1]}
                                            : adder_sum[Width-1:0];
                    if (cnt_q == '0) state_q <= FIXUP;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                FIXUP: begin
                    result_q <= fix_neg ? adder_sum[Width-1:0] : fix_val;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_panda_divider.sv
// Directed bench for panda_divider: results, latency, backpressure, reset
// and (with PANDA_DIV_FLUSH_EN) flush behaviour.
module tb_panda_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [1:0]  op = 2'b00;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;
`ifdef PANDA_DIV_FLUSH_EN
    logic        flush_i = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    panda_divider #(.Width(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
`ifdef PANDA_DIV_FLUSH_EN
        .flush_i     (flush_i),
`endif
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .operand_a_i (operand_a),
        .operand_b_i (operand_b),
        .op_i        (op),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o)
    );

    // Issue one request from IDLE, wait for valid_o and consume it.
    // lat counts cycles from the accept edge; 999 marks a timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                          output logic [31:0] res, output int lat);
        operand_a = a;
        operand_b = b;
        op        = o;
        valid_i   = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!valid_o) lat = 999;
        res = result_o;
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++;
        if (result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
        $display("reset: ready_o=%b valid_o=%b result_o=%h", ready_o, valid_o, result_o);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Vectors: a, b, op, expected result, expected latency.
    task automatic test_vectors();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [1:0]  vo [10];
        logic [31:0] ve [10];
        int          vl [10];
        logic [31:0] res;
        int          lat;
        va[0] = 32'd100;      vb[0] = 32'd7;        vo[0] = 2'b01; ve[0] = 32'd14;       vl[0] = 36;
        va[1] = 32'd100;      vb[1] = 32'd7;        vo[1] = 2'b11; ve[1] = 32'd2;        vl[1] = 36;
        va[2] = 32'hFFFFFFF9; vb[2] = 32'd2;        vo[2] = 2'b00; ve[2] = 32'hFFFFFFFD; vl[2] = 36;
        va[3] = 32'hFFFFFFF9; vb[3] = 32'd2;        vo[3] = 2'b10; ve[3] = 32'hFFFFFFFF; vl[3] = 36;
        va[4] = 32'd100;      vb[4] = 32'hFFFFFFF9; vo[4] = 2'b00; ve[4] = 32'hFFFFFFF2; vl[4] = 36;
        va[5] = 32'hFFFFFF9C; vb[5] = 32'd7;        vo[5] = 2'b10; ve[5] = 32'hFFFFFFFE; vl[5] = 36;
        va[6] = 32'd5;        vb[6] = 32'd0;        vo[6] = 2'b00; ve[6] = 32'hFFFFFFFF; vl[6] = 1;
        va[7] = 32'd5;        vb[7] = 32'd0;        vo[7] = 2'b11; ve[7] = 32'd5;        vl[7] = 1;
        va[8] = 32'h80000000; vb[8] = 32'hFFFFFFFF; vo[8] = 2'b00; ve[8] = 32'h80000000; vl[8] = 1;
        va[9] = 32'h80000000; vb[9] = 32'hFFFFFFFF; vo[9] = 2'b10; ve[9] = 32'h0;        vl[9] = 1;
        for (int i = 0; i < 10; i++) begin
            run_op(va[i], vb[i], vo[i], res, lat);
            total++;
            if (res !== ve[i]) begin
                bad++;
                $display("FAIL vec%0d_result got=%h want=%h", i, res, ve[i]);
            end
            total++;
            if (lat != vl[i]) begin
                bad++;
                $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, vl[i]);
            end
            $display("op=%b a=%h b=%h result=%h latency=%0d", vo[i], va[i], vb[i], res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int errs;
        operand_a = 32'd1000;
        operand_b = 32'd10;
        op        = 2'b01;
        valid_i   = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
        total++;
        if (!valid_o || result_o !== 32'd100) begin
            bad++;
            $display("FAIL bp_first_result got=%h valid=%b want=00000064", result_o, valid_o);
        end
        // Hold off the consumer while hammering valid_i with a different request.
        operand_a = 32'd9;
        operand_b = 32'd3;
        valid_i   = 1'b1;
        errs = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b1 || result_o !== 32'd100 || ready_o !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_hold got=%0d bad cycles want=0 (valid=%b result=%h ready=%b)",
                     errs, valid_o, result_o, ready_o);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        valid_i = 1'b0;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", valid_o, ready_o);
        end
        @(posedge clk); #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_accept got ready=%b want=1", ready_o);
        end
        $display("backpressure: held result=%h then released", result_o);
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        operand_a = 32'd50000;
        operand_b = 32'd3;
        op        = 2'b01;
        valid_i   = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset got ready=%b valid=%b result=%h want 1 0 00000000",
                     ready_o, valid_o, result_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(32'hFFFFFFFF, 32'd1, 2'b01, res, lat);
        total++;
        if (res !== 32'hFFFFFFFF || lat != 36) begin
            bad++;
            $display("FAIL post_reset_op got=%h lat=%0d want=ffffffff lat=36", res, lat);
        end
        $display("mid reset recovered: result=%h latency=%0d", res, lat);
    endtask

`ifdef PANDA_DIV_FLUSH_EN
    task automatic test_flush();
        logic [31:0] prev;
        int          seen;
        prev      = result_o;
        operand_a = 32'd77;
        operand_b = 32'd5;
        op        = 2'b00;
        valid_i   = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== prev) begin
            bad++;
            $display("FAIL flush_idle got ready=%b valid=%b result=%h want 1 0 %h",
                     ready_o, valid_o, result_o, prev);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL flush_no_valid got=%0d valid cycles want=0", seen);
        end
        $display("flush in ABS_B: returned to IDLE");
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
`ifdef PANDA_DIV_FLUSH_EN
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
